sram_axi_bridge: RTL and testbench
==================================

# sram_axi_bridge

Converts the core's two SRAM-like request ports (instruction fetch, data load/store) into one AXI3 master port for `mycpu_top`. Sits directly downstream of `exe_core`: it produces `inst_addr_ok`/`inst_data_ok`/`inst_rdata` and the data-side equivalents, and drives every AXI channel. Each burst is a single beat. The bridge holds at most one read and one write in flight.

## Interface
- No parameters.
- `aclk` in 1: clock.
- `aresetn` in 1: asynchronous active-low reset.
- `inst_req` in 1; `inst_addr` in 32; `inst_size` in 3: fetch request.
- `inst_addr_ok` out 1: request accepted this cycle.
- `inst_data_ok` out 1; `inst_rdata` out 32: fetch return.
- `data_req` in 1; `data_wr` in 1; `data_size` in 3; `data_addr` in 32; `data_wstrb` in 4; `data_wdata` in 32: load/store request.
- `data_addr_ok` out 1; `data_data_ok` out 1; `data_rdata` out 32: data handshakes and return.
- AR: `arid` 4, `araddr` 32, `arlen` 4, `arsize` 3, `arburst` 2, `arlock` 2, `arcache` 4, `arprot` 3, `arvalid` out; `arready` in.
- R: `rid` 4, `rdata` 32, `rresp` 2, `rlast` 1, `rvalid` in; `rready` out.
- AW: `awid`, `awaddr`, `awlen`, `awsize`, `awburst`, `awlock`, `awcache`, `awprot`, `awvalid` out (same widths as AR); `awready` in.
- W: `wid` 4, `wdata` 32, `wstrb` 4, `wlast` 1, `wvalid` out; `wready` in.
- B: `bid` 4, `bresp` 2, `bvalid` in; `bready` out.

## Operation
- Constant outputs: `arlen`/`awlen`=0, `arburst`/`awburst`=2'b01, lock/cache/prot=0, `awid`/`wid`=1, `wlast`=1.
- `arid`: 0 for instruction, 1 for data.
- `arsize`/`awsize` = `{1'b0, size[1:0]}`.
- `rresp`/`bresp` are ignored. `rlast` is ignored because every burst is one beat.
- Busy flags `inst_busy` and `data_busy`:
  - Set on the port's addr_ok.
  - Cleared on the port's data_ok.
  - A port with its busy flag set never gets addr_ok, so each port has one outstanding transaction.
- Read FSM has three states:
  - R_IDLE: on an accepted read, latch addr/size/id and go to R_AR.
  - R_AR: `arvalid`=1; on `arready` go to R_R.
  - R_R: `rready`=1; on `rvalid` capture `rdata` and `rid`, go to R_IDLE.
- Write FSM has three states:
  - W_IDLE: on an accepted data write, latch addr/size/strb/wdata and go to W_REQ.
  - W_REQ: `awvalid` and `wvalid` are asserted together. Each drops independently after its own ready. When both have handshaken (same or different cycles), go to W_RESP.
  - W_RESP: `bready`=1; on `bvalid` go to W_IDLE.
- Acceptance, combinational in the request cycle:
  - Instruction read: `inst_req & !inst_busy & R_IDLE`, and arbitration not lost to a data read.
  - Data read: `data_req & !data_wr & !data_busy & R_IDLE`, and arbitration not lost.
  - Data write: `data_req & data_wr & !data_busy & W_IDLE`.
  - A write and an instruction read may be accepted in the same cycle.
- Returns:
  - `inst_data_ok` pulses one cycle after an R handshake with `rid`=0.
  - `data_data_ok` pulses one cycle after an R handshake with `rid`=1, or one cycle after a B handshake.
  - `*_rdata` are registered and held until the next return.
- At most one data transaction is outstanding, so the R and B returns never collide on `data_data_ok`.

## Timing
- Reset values: all valid/ready outputs 0, both data_ok 0, rdata outputs 0, `araddr`/`awaddr`/`wdata`/`wstrb` 0, FSMs idle, busy flags 0.
- Cycle 0: addr_ok. Cycle 1: `arvalid` or `awvalid`/`wvalid` high.
- Minimum read latency is 3 cycles from addr_ok to data_ok (AR cycle 1, R cycle 2, data_ok cycle 3).
- Minimum write latency is 3 cycles (AW/W cycle 1, B cycle 2, data_ok cycle 3).
- Valids stay asserted with stable payload until their ready arrives.
- Reset asserted mid-transaction returns everything to reset values immediately. In-flight AXI transfers are abandoned; the interconnect is reset by the same signal.

## Configuration
- `BRIDGE_INST_PRIORITY_EN`:
  - Defined: an instruction read wins when it contends with a data read in R_IDLE in the same cycle.
  - Undefined (default): the data read wins. The losing port keeps its request and is considered on the next R_IDLE cycle.

## Test plan
- Instruction read: `inst_req` with addr 0xBFC00000 and `arready`/`rvalid` tied high.
  - `arvalid` at cycle 1 with `araddr`=0xBFC00000, `arid`=0.
  - `inst_data_ok` at cycle 3 with `inst_rdata` equal to the returned word.
- Store with split handshakes: addr 0x80001004, wstrb 4'b0011, wdata 0x1234ABCD, `awready` at cycle 1, `wready` at cycle 4.
  - `awvalid` drops after cycle 1; `wvalid` holds until cycle 4.
  - `bready` from cycle 5; `data_data_ok` one cycle after `bvalid`.
- Contention in the same cycle (inst 0x1000, data load 0x2000):
  - Default build: `data_addr_ok`=1, `inst_addr_ok`=0, first `araddr`=0x2000.
  - With `BRIDGE_INST_PRIORITY_EN`: first `araddr`=0x1000.
- Store accepted concurrently with a fetch: both addr_ok in the same cycle, AR and AW both valid at cycle 1, both data_ok delivered correctly.
- Backpressure: with `data_busy` set, a second `data_req` gets `data_addr_ok`=0 until one cycle after `data_data_ok`.
- Reset mid-read, with `aresetn` dropped while in R_R: `rready`, `arvalid` and `inst_data_ok` are 0 immediately; after release a new fetch completes normally.

Source files
------------

// File: rtl/sram_axi_bridge.sv
// SRAM-like fetch/data ports to a single-beat AXI3 master, one read and one write in flight.
// Optional `BRIDGE_INST_PRIORITY_EN: fetch wins read arbitration (default: data read wins).
module sram_axi_bridge (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic [2:0]  inst_size,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [2:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  // state   | meaning
  // R_IDLE  | no read outstanding, may accept a fetch or load
  // R_AR    | arvalid high, waiting for arready
  // R_R     | rready high, waiting for the single R beat
  // W_IDLE  | no write outstanding, may accept a store
  // W_REQ   | awvalid/wvalid raised, each drops on its own ready
  // W_RESP  | bready high, waiting for the write response
  typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_e;

  r_state_e    r_state_q, r_state_d;
  w_state_e    w_state_q, w_state_d;
  logic        inst_busy_q, inst_busy_d;
  logic        data_busy_q, data_busy_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic [31:0] araddr_q, araddr_d;
  logic [2:0]  arsize_q, arsize_d;
  logic [3:0]  arid_q, arid_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [2:0]  awsize_q, awsize_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        inst_data_ok_q, inst_data_ok_d;
  logic        data_data_ok_q, data_data_ok_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;

  logic inst_cand, data_rd_cand, data_wr_acc;
  logic inst_acc, data_rd_acc;
  logic aw_done, w_done;
  logic unused_ok;

  assign unused_ok = ^{rresp, rlast, bid, bresp, inst_size[2], data_size[2]};

  always_comb begin
    inst_cand    = inst_req & ~inst_busy_q & (r_state_q == R_IDLE);
    data_rd_cand = data_req & ~data_wr & ~data_busy_q & (r_state_q == R_IDLE);
    data_wr_acc  = data_req & data_wr & ~data_busy_q & (w_state_q == W_IDLE);
`ifdef BRIDGE_INST_PRIORITY_EN
    inst_acc     = inst_cand;
    data_rd_acc  = data_rd_cand & ~inst_cand;
`else
    inst_acc     = inst_cand & ~data_rd_cand;
    data_rd_acc  = data_rd_cand;
`endif
  end

  assign inst_addr_ok = inst_acc;
  assign data_addr_ok = data_rd_acc | data_wr_acc;

  always_comb begin
    r_state_d      = r_state_q;
    w_state_d      = w_state_q;
    arvalid_d      = arvalid_q;
    rready_d       = rready_q;
    awvalid_d      = awvalid_q;
    wvalid_d       = wvalid_q;
    bready_d       = bready_q;
    araddr_d       = araddr_q;
    arsize_d       = arsize_q;
    arid_d         = arid_q;
    awaddr_d       = awaddr_q;
    awsize_d       = awsize_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    inst_rdata_d   = inst_rdata_q;
    data_rdata_d   = data_rdata_q;
    inst_data_ok_d = 1'b0;
    data_data_ok_d = 1'b0;
    aw_done        = ~awvalid_q | awready;
    w_done         = ~wvalid_q | wready;

    case (r_state_q)
      R_IDLE: begin
        if (inst_acc | data_rd_acc) begin
          r_state_d = R_AR;
          arvalid_d = 1'b1;
          araddr_d  = inst_acc ? inst_addr : data_addr;
          arsize_d  = {1'b0, (inst_acc ? inst_size[1:0] : data_size[1:0])};
          arid_d    = inst_acc ? 4'd0 : 4'd1;
        end
      end
      R_AR: begin
        if (arready) begin
          r_state_d = R_R;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      R_R: begin
        if (rvalid) begin
          r_state_d = R_IDLE;
          rready_d  = 1'b0;
          // rid, not the latched arid, steers the return
          if (rid == 4'd0) begin
            inst_rdata_d   = rdata;
            inst_data_ok_d = 1'b1;
          end else begin
            data_rdata_d   = rdata;
            data_data_ok_d = 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase

    case (w_state_q)
      W_IDLE: begin
        if (data_wr_acc) begin
          w_state_d = W_REQ;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = data_addr;
          awsize_d  = {1'b0, data_size[1:0]};
          wdata_d   = data_wdata;
          wstrb_d   = data_wstrb;
        end
      end
      W_REQ: begin
        if (awvalid_q & awready) awvalid_d = 1'b0;
        if (wvalid_q & wready)   wvalid_d  = 1'b0;
        if (aw_done & w_done) begin
          w_state_d = W_RESP;
          bready_d  = 1'b1;
        end
      end
      W_RESP: begin
        if (bvalid) begin
          w_state_d      = W_IDLE;
          bready_d       = 1'b0;
          data_data_ok_d = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase

    inst_busy_d = inst_acc ? 1'b1 : (inst_data_ok_q ? 1'b0 : inst_busy_q);
    data_busy_d = data_addr_ok ? 1'b1 : (data_data_ok_q ? 1'b0 : data_busy_q);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q      <= R_IDLE;
      w_state_q      <= W_IDLE;
      inst_busy_q    <= 1'b0;
      data_busy_q    <= 1'b0;
      arvalid_q      <= 1'b0;
      rready_q       <= 1'b0;
      awvalid_q      <= 1'b0;
      wvalid_q       <= 1'b0;
      bready_q       <= 1'b0;
      araddr_q       <= 32'd0;
      arsize_q       <= 3'd0;
      arid_q         <= 4'd0;
      awaddr_q       <= 32'd0;
      awsize_q       <= 3'd0;
      wdata_q        <= 32'd0;
      wstrb_q        <= 4'd0;
      inst_data_ok_q <= 1'b0;
      data_data_ok_q <= 1'b0;
      inst_rdata_q   <= 32'd0;
      data_rdata_q   <= 32'd0;
    end else begin
      r_state_q      <= r_state_d;
      w_state_q      <= w_state_d;
      inst_busy_q    <= inst_busy_d;
      data_busy_q    <= data_busy_d;
      arvalid_q      <= arvalid_d;
      rready_q       <= rready_d;
      awvalid_q      <= awvalid_d;
      wvalid_q       <= wvalid_d;
      bready_q       <= bready_d;
      araddr_q       <= araddr_d;
      arsize_q       <= arsize_d;
      arid_q         <= arid_d;
      awaddr_q       <= awaddr_d;
      awsize_q       <= awsize_d;
      wdata_q        <= wdata_d;
      wstrb_q        <= wstrb_d;
      inst_data_ok_q <= inst_data_ok_d;
      data_data_ok_q <= data_data_ok_d;
      inst_rdata_q   <= inst_rdata_d;
      data_rdata_q   <= data_rdata_d;
    end
  end

  assign inst_data_ok = inst_data_ok_q;
  assign inst_rdata   = inst_rdata_q;
  assign data_data_ok = data_data_ok_q;
  assign data_rdata   = data_rdata_q;

  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arlen   = 4'd0;
  assign arsize  = arsize_q;
  assign arburst = 2'b01;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

  assign awid    = 4'd1;
  assign awaddr  = awaddr_q;
  assign awlen   = 4'd0;
  assign awsize  = awsize_q;
  assign awburst = 2'b01;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awvalid = awvalid_q;

  assign wid     = 4'd1;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Bench for sram_axi_bridge: directed scenarios plus a transaction scoreboard
// that predicts AXI payloads and returned words from the request ports.
module tb_sram_axi_bridge;

`ifdef BRIDGE_INST_PRIORITY_EN
  localparam bit INST_PRIO = 1'b1;
`else
  localparam bit INST_PRIO = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = 32'd0;
  logic [2:0]  inst_size = 3'd2;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0, data_wr = 1'b0;
  logic [2:0]  data_size = 3'd2;
  logic [31:0] data_addr = 32'd0, data_wdata = 32'd0;
  logic [3:0]  data_wstrb = 4'd0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb;
  logic [31:0] araddr, awaddr, wdata;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock;
  logic        arvalid, rready, awvalid, wvalid, wlast, bready;
  logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [3:0]  bid = 4'd1;
  logic [1:0]  rresp = 2'd0, bresp = 2'd0;
  logic        rlast = 1'b1;

  // slave memory: word returned for an address is its bitwise inverse
  logic [31:0] ar_addr_lat = 32'd0;
  logic [3:0]  ar_id_lat = 4'd0;
  assign rdata = ~ar_addr_lat;
  assign rid   = ar_id_lat;
  always @(posedge aclk) if (arvalid && arready) begin
    ar_addr_lat <= araddr;
    ar_id_lat   <= arid;
  end

  always #5 aclk = ~aclk;

  sram_axi_bridge dut (
    .aclk(aclk), .aresetn(aresetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard
  logic [31:0] ar_addr_q[$];
  logic [3:0]  ar_id_q[$];
  logic [2:0]  ar_size_q[$];
  logic [34:0] aw_q[$];       // {size, addr}
  logic [35:0] w_q[$];        // {strb, data}
  logic [31:0] inst_exp_q[$];
  logic [32:0] data_exp_q[$]; // {is_store, word}
  logic [31:0] last_load = 32'd0;
  bit ar_pend = 0, aw_pend = 0, w_pend = 0;

  always @(negedge aclk) begin
    if (!aresetn) begin
      ar_addr_q.delete(); ar_id_q.delete(); ar_size_q.delete();
      aw_q.delete(); w_q.delete(); inst_exp_q.delete(); data_exp_q.delete();
      last_load = 32'd0;
      ar_pend = 0; aw_pend = 0; w_pend = 0;
    end else begin
      if (inst_addr_ok) begin
        ar_addr_q.push_back(inst_addr); ar_id_q.push_back(4'd0);
        ar_size_q.push_back({1'b0, inst_size[1:0]});
        inst_exp_q.push_back(~inst_addr);
      end
      if (data_addr_ok && !data_wr) begin
        ar_addr_q.push_back(data_addr); ar_id_q.push_back(4'd1);
        ar_size_q.push_back({1'b0, data_size[1:0]});
        data_exp_q.push_back({1'b0, ~data_addr});
      end
      if (data_addr_ok && data_wr) begin
        aw_q.push_back({1'b0, data_size[1:0], data_addr});
        w_q.push_back({data_wstrb, data_wdata});
        data_exp_q.push_back({1'b1, 32'd0});
      end
      if (ar_pend) chk("ar_hold", arvalid, 1'b1);
      if (aw_pend) chk("aw_hold", awvalid, 1'b1);
      if (w_pend)  chk("w_hold", wvalid, 1'b1);
      if (arvalid) begin
        if (ar_addr_q.size() == 0) chk("ar_unexpected", arvalid, 1'b0);
        else begin
          chk("ar_payload", {arid, arsize, araddr}, {ar_id_q[0], ar_size_q[0], ar_addr_q[0]});
          if (arready) begin
            void'(ar_addr_q.pop_front()); void'(ar_id_q.pop_front()); void'(ar_size_q.pop_front());
          end
        end
      end
      if (awvalid) begin
        if (aw_q.size() == 0) chk("aw_unexpected", awvalid, 1'b0);
        else begin
          chk("aw_payload", {awsize, awaddr}, aw_q[0]);
          if (awready) void'(aw_q.pop_front());
        end
      end
      if (wvalid) begin
        if (w_q.size() == 0) chk("w_unexpected", wvalid, 1'b0);
        else begin
          chk("w_payload", {wstrb, wdata}, w_q[0]);
          if (wready) void'(w_q.pop_front());
        end
      end
      ar_pend = arvalid && !arready;
      aw_pend = awvalid && !awready;
      w_pend  = wvalid && !wready;
      if (inst_data_ok) begin
        if (inst_exp_q.size() == 0) chk("inst_ok_unexpected", inst_data_ok, 1'b0);
        else chk("inst_rdata", inst_rdata, inst_exp_q.pop_front());
      end
      if (data_data_ok) begin
        if (data_exp_q.size() == 0) chk("data_ok_unexpected", data_data_ok, 1'b0);
        else begin
          logic [32:0] e;
          e = data_exp_q.pop_front();
          if (e[32]) chk("data_rdata_held", data_rdata, last_load);
          else begin
            chk("data_rdata", data_rdata, e[31:0]);
            last_load = e[31:0];
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge aclk); #1;
  endtask

  task automatic wait_ok(input bit is_data, input string name);
    int k;
    k = 0;
    @(negedge aclk);
    while (!(is_data ? data_data_ok : inst_data_ok) && k < 30) begin
      @(negedge aclk);
      k++;
    end
    chk(name, is_data ? data_data_ok : inst_data_ok, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    step(); step();
    @(negedge aclk);
    chk("rst_valids", {arvalid, rready, awvalid, wvalid, bready, inst_data_ok, data_data_ok}, 7'd0);
    chk("rst_rdata", {inst_rdata, data_rdata}, 64'd0);
    chk("rst_addr", {araddr, awaddr}, 64'd0);
    chk("rst_wpayload", {wstrb, wdata}, 36'd0);
    chk("tieoffs", {arlen, arburst, arlock, arcache, arprot, awlen, awburst, awlock, awcache, awprot},
        {4'd0, 2'b01, 2'd0, 4'd0, 3'd0, 4'd0, 2'b01, 2'd0, 4'd0, 3'd0});
    chk("ids_wlast", {awid, wid, wlast}, {4'd1, 4'd1, 1'b1});
    step(); aresetn = 1'b1;
    step();

    // fetch with AR/R ready tied high
    arready = 1; rvalid = 1;
    inst_req = 1; inst_addr = 32'hBFC0_0000; inst_size = 3'd2;
    @(negedge aclk); chk("t1_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b10);
    step(); inst_req = 0;
    @(negedge aclk); chk("t1_ar_c1", {arvalid, arid, araddr}, {1'b1, 4'd0, 32'hBFC0_0000});
    step();
    @(negedge aclk); chk("t1_r_c2", {arvalid, rready}, 2'b01);
    step();
    @(negedge aclk); chk("t1_ok_c3", {inst_data_ok, inst_rdata}, {1'b1, 32'h403F_FFFF});
    step();
    @(negedge aclk); chk("t1_ok_pulse", inst_data_ok, 1'b0);
    arready = 0; rvalid = 0;
    step();

    // store with AW and W handshakes in different cycles
    data_req = 1; data_wr = 1; data_addr = 32'h8000_1004; data_size = 3'd2;
    data_wstrb = 4'b0011; data_wdata = 32'h1234_ABCD;
    @(negedge aclk); chk("t2_addr_ok", data_addr_ok, 1'b1);
    step(); data_req = 0; data_wr = 0; awready = 1;
    @(negedge aclk); chk("t2_c1", {awvalid, wvalid, awaddr, wstrb, wdata},
                         {1'b1, 1'b1, 32'h8000_1004, 4'b0011, 32'h1234_ABCD});
    step(); awready = 0;
    @(negedge aclk); chk("t2_c2", {awvalid, wvalid, bready}, 3'b010);
    step();
    @(negedge aclk); chk("t2_c3", {awvalid, wvalid, bready}, 3'b010);
    step(); wready = 1;
    @(negedge aclk); chk("t2_c4", {awvalid, wvalid, bready}, 3'b010);
    step(); wready = 0;
    @(negedge aclk); chk("t2_c5", {awvalid, wvalid, bready, data_data_ok}, 4'b0010);
    step(); bvalid = 1;
    @(negedge aclk); chk("t2_c6", {bready, data_data_ok}, 2'b10);
    step(); bvalid = 0;
    @(negedge aclk); chk("t2_c7", {bready, data_data_ok}, 2'b01);
    step();

    // fetch and load contending in the same cycle
    inst_req = 1; inst_addr = 32'h1000;
    data_req = 1; data_wr = 0; data_addr = 32'h2000;
    @(negedge aclk); chk("t3_arb", {inst_addr_ok, data_addr_ok}, INST_PRIO ? 2'b10 : 2'b01);
    step();
    if (INST_PRIO) inst_req = 0; else data_req = 0;
    arready = 1;
    @(negedge aclk);
    chk("t3_first_ar", {arvalid, araddr}, {1'b1, (INST_PRIO ? 32'h1000 : 32'h2000)});
    chk("t3_loser_wait", {inst_addr_ok, data_addr_ok}, 2'b00);
    step(); rvalid = 1;
    @(negedge aclk); chk("t3_rready", rready, 1'b1);
    step();
    @(negedge aclk);
    chk("t3_win_ok", INST_PRIO ? data_data_ok : inst_data_ok, 1'b0);
    chk("t3_win_ok", INST_PRIO ? inst_data_ok : data_data_ok, 1'b1);
    chk("t3_loser_accept", {inst_addr_ok, data_addr_ok}, INST_PRIO ? 2'b01 : 2'b10);
    step(); inst_req = 0; data_req = 0;
    @(negedge aclk); chk("t3_second_ar", araddr, INST_PRIO ? 32'h2000 : 32'h1000);
    wait_ok(INST_PRIO, "t3_loser_ok");
    step(); arready = 0; rvalid = 0;
    step();

    // store accepted together with a fetch
    arready = 1; rvalid = 1; awready = 1; wready = 1; bvalid = 1;
    inst_req = 1; inst_addr = 32'h3000;
    data_req = 1; data_wr = 1; data_addr = 32'h4000; data_wstrb = 4'hF; data_wdata = 32'hCAFE_F00D;
    @(negedge aclk); chk("t4_both_ok", {inst_addr_ok, data_addr_ok}, 2'b11);
    step(); inst_req = 0; data_req = 0; data_wr = 0;
    @(negedge aclk); chk("t4_c1", {arvalid, awvalid, wvalid}, 3'b111);
    step();
    @(negedge aclk); chk("t4_c2", {rready, bready}, 2'b11);
    step();
    @(negedge aclk); chk("t4_c3", {inst_data_ok, data_data_ok}, 2'b11);
    step(); arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
    step();

    // second load held off while the first is outstanding
    arready = 1;
    data_req = 1; data_wr = 0; data_addr = 32'h5000;
    @(negedge aclk); chk("t5_first_ok", data_addr_ok, 1'b1);
    step(); data_addr = 32'h6000;
    for (int c = 1; c <= 4; c++) begin
      if (c == 3) rvalid = 1;
      @(negedge aclk);
      chk("t5_backpressure", data_addr_ok, 1'b0);
      if (c == 4) chk("t5_first_ret", data_data_ok, 1'b1);
      step();
    end
    @(negedge aclk); chk("t5_second_ok", data_addr_ok, 1'b1);
    step(); data_req = 0;
    wait_ok(1'b1, "t5_second_ret");
    step(); arready = 0; rvalid = 0;
    step();

    // reset while waiting for the R beat
    arready = 1;
    inst_req = 1; inst_addr = 32'h7000;
    @(negedge aclk); chk("t6_addr_ok", inst_addr_ok, 1'b1);
    step(); inst_req = 0;
    step();
    @(negedge aclk); chk("t6_in_r", rready, 1'b1);
    #2 aresetn = 0; rvalid = 1;
    #1 chk("t6_reset_now", {rready, arvalid, inst_data_ok}, 3'b000);
    step(); step(); aresetn = 1;
    step();
    inst_req = 1; inst_addr = 32'h8000;
    @(negedge aclk); chk("t6_refetch_ok", inst_addr_ok, 1'b1);
    step(); inst_req = 0;
    wait_ok(1'b0, "t6_refetch_ret");
    step(); arready = 0; rvalid = 0;
    step(); step();

    chk("sb_drained", ar_addr_q.size() + aw_q.size() + w_q.size() + inst_exp_q.size() + data_exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
